// File: rtl/wired_rob_ctrl_if.sv
// Dispatch/commit bundle between the ROB sequencer (master) and the pipeline/ROB arrays (slave).
interface wired_rob_ctrl_if #(
  parameter int ROB_LEN = 6
);
  logic [1:0]              d_req_i;
  logic                    d_ready_o;
  logic [1:0][ROB_LEN-1:0] d_rid_o;
  logic [1:0]              p_valid_o;
  logic [1:0][ROB_LEN-1:0] c_rrrid_o;
  logic [1:0]              c_rob_valid_i;
  logic [1:0]              c_excp_i;
  logic [1:0]              c_retire_o;
  logic                    c_walk_o;
  logic                    flush_o;
  logic [ROB_LEN:0]        count_o;
  logic                    empty_o;
  logic                    full_o;

  modport master (
    input  d_req_i, c_rob_valid_i, c_excp_i,
    output d_ready_o, d_rid_o, p_valid_o, c_rrrid_o, c_retire_o,
           c_walk_o, flush_o, count_o, empty_o, full_o
  );

  modport slave (
    output d_req_i, c_rob_valid_i, c_excp_i,
    input  d_ready_o, d_rid_o, p_valid_o, c_rrrid_o, c_retire_o,
           c_walk_o, flush_o, count_o, empty_o, full_o
  );
endinterface

// File: rtl/wired_rob_ctrl.sv
// ROB sequencer: head/tail/count ownership, 2-wide allocation, in-order retire,
// and a post-exception walk that drains every younger entry through the retire port.
module wired_rob_ctrl #(
  parameter int ROB_LEN = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  wired_rob_ctrl_if.master rob
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WALK    = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  localparam logic [ROB_LEN:0] DEPTH = {1'b1, {ROB_LEN{1'b0}}};

  state_e             state_r, state_nxt_s;
  logic [ROB_LEN-1:0] head_r, tail_r;
  logic [ROB_LEN:0]   count_r, count_nxt_s;
  logic [ROB_LEN:0]   free_s, req_cnt_s, alloc_cnt_s, retire_cnt_s;
  logic [1:0]         req_s, p_valid_s, retire_s;
  logic               d_ready_s, excp_hit_s;
  logic               run_r0_s, run_r1_s;

  // The illegal slot-1-only request is dropped so a pair is never split.
  assign req_s     = (rob.d_req_i == 2'b10) ? 2'b00 : rob.d_req_i;
  assign req_cnt_s = (ROB_LEN+1)'(req_s[0]) + (ROB_LEN+1)'(req_s[1]);
  assign free_s    = DEPTH - count_r;

  assign run_r0_s = (count_r >= (ROB_LEN+1)'(1)) & rob.c_rob_valid_i[0];
  assign run_r1_s = run_r0_s & ~rob.c_excp_i[0] & (count_r >= (ROB_LEN+1)'(2))
                  & rob.c_rob_valid_i[1];

  assign alloc_cnt_s  = (ROB_LEN+1)'(p_valid_s[0]) + (ROB_LEN+1)'(p_valid_s[1]);
  assign retire_cnt_s = (ROB_LEN+1)'(retire_s[0]) + (ROB_LEN+1)'(retire_s[1]);
  // Free space comes from the pre-retire count, so a full ROB never refills in the retiring cycle.
  assign count_nxt_s  = count_r + alloc_cnt_s - retire_cnt_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {ROB_LEN{1'b0}};
      tail_r  <= {ROB_LEN{1'b0}};
      count_r <= {(ROB_LEN+1){1'b0}};
    end else begin
      head_r  <= head_r + ROB_LEN'(retire_cnt_s);
      tail_r  <= tail_r + ROB_LEN'(alloc_cnt_s);
      count_r <= count_nxt_s;
    end
  end

  // Next-state logic: an excepting retire starts the walk, which ends once the ROB drains.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (excp_hit_s) begin
          state_nxt_s = (count_nxt_s == '0) ? ST_RECOVER : ST_WALK;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_WALK: begin
        if (count_nxt_s == '0) begin
          state_nxt_s = ST_RECOVER;
        end else begin
          state_nxt_s = ST_WALK;
        end
      end
      ST_RECOVER: state_nxt_s = ST_RUN;
      default:    state_nxt_s = ST_RUN;
    endcase
  end

  // Output decode: allocation grant and retire vector per state.
  always_comb begin
    d_ready_s  = 1'b0;
    retire_s   = 2'b00;
    excp_hit_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        d_ready_s  = (free_s >= req_cnt_s);
        retire_s   = {run_r1_s, run_r0_s};
        excp_hit_s = (run_r0_s & rob.c_excp_i[0]) | (run_r1_s & rob.c_excp_i[1]);
      end
      ST_WALK: begin
        retire_s = {count_r >= (ROB_LEN+1)'(2), count_r >= (ROB_LEN+1)'(1)};
      end
      ST_RECOVER: retire_s = 2'b00;
      default:    retire_s = 2'b00;
    endcase
    p_valid_s = req_s & {2{d_ready_s}};
  end

  assign rob.d_ready_o    = d_ready_s;
  assign rob.p_valid_o    = p_valid_s;
  assign rob.d_rid_o[0]   = tail_r;
  assign rob.d_rid_o[1]   = tail_r + ROB_LEN'(1);
  assign rob.c_rrrid_o[0] = head_r;
  assign rob.c_rrrid_o[1] = head_r + ROB_LEN'(1);
  assign rob.c_retire_o   = retire_s;
  assign rob.c_walk_o     = (state_r == ST_WALK);
  assign rob.flush_o      = (state_r != ST_RUN);
  assign rob.count_o      = count_r;
  assign rob.empty_o      = (count_r == '0);
  assign rob.full_o       = (count_r == DEPTH);

endmodule

// File: tb/tb_wired_rob_ctrl.sv
// Bench for wired_rob_ctrl: a 64-entry and a 4-entry instance share stimulus and are
// each compared every cycle against an occupancy/pointer reference model.
module tb_wired_rob_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wired_rob_ctrl_if #(.ROB_LEN(6)) bus6 ();
  wired_rob_ctrl_if #(.ROB_LEN(2)) bus2 ();

  wired_rob_ctrl #(.ROB_LEN(6)) dut6 (.clk(clk), .rst_n(rst_n), .rob(bus6.master));
  wired_rob_ctrl #(.ROB_LEN(2)) dut2 (.clk(clk), .rst_n(rst_n), .rob(bus2.master));

  logic [31:0] o_ready[2], o_pv[2], o_rid[2], o_rr[2], o_ret[2];
  logic [31:0] o_walk[2], o_flush[2], o_cnt[2], o_empty[2], o_full[2];

  assign o_ready[0] = 32'(bus6.d_ready_o);
  assign o_pv[0]    = 32'(bus6.p_valid_o);
  assign o_rid[0]   = {16'(bus6.d_rid_o[1]), 16'(bus6.d_rid_o[0])};
  assign o_rr[0]    = {16'(bus6.c_rrrid_o[1]), 16'(bus6.c_rrrid_o[0])};
  assign o_ret[0]   = 32'(bus6.c_retire_o);
  assign o_walk[0]  = 32'(bus6.c_walk_o);
  assign o_flush[0] = 32'(bus6.flush_o);
  assign o_cnt[0]   = 32'(bus6.count_o);
  assign o_empty[0] = 32'(bus6.empty_o);
  assign o_full[0]  = 32'(bus6.full_o);

  assign o_ready[1] = 32'(bus2.d_ready_o);
  assign o_pv[1]    = 32'(bus2.p_valid_o);
  assign o_rid[1]   = {16'(bus2.d_rid_o[1]), 16'(bus2.d_rid_o[0])};
  assign o_rr[1]    = {16'(bus2.c_rrrid_o[1]), 16'(bus2.c_rrrid_o[0])};
  assign o_ret[1]   = 32'(bus2.c_retire_o);
  assign o_walk[1]  = 32'(bus2.c_walk_o);
  assign o_flush[1] = 32'(bus2.flush_o);
  assign o_cnt[1]   = 32'(bus2.count_o);
  assign o_empty[1] = 32'(bus2.empty_o);
  assign o_full[1]  = 32'(bus2.full_o);

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 = normal, 1 = draining after exception, 2 = one-cycle recovery.
  int depth[2] = '{64, 4};
  int m_head[2], m_tail[2], m_cnt[2], m_mode[2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] vld, input logic [1:0] exc);
    bus6.d_req_i = req; bus6.c_rob_valid_i = vld; bus6.c_excp_i = exc;
    bus2.d_req_i = req; bus2.c_rob_valid_i = vld; bus2.c_excp_i = exc;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_head[k] = 0; m_tail[k] = 0; m_cnt[k] = 0; m_mode[k] = 0;
    end
  endtask

  task automatic do_reset();
    drive(2'b00, 2'b00, 2'b00);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, compare combinational view, then advance the model at posedge.
  task automatic cycle(input logic [1:0] req, input logic [1:0] vld, input logic [1:0] exc);
    logic [1:0] sreq;
    int na[2], nr[2], ht[2];
    @(negedge clk);
    drive(req, vld, exc);
    #1;
    sreq = (req == 2'b10) ? 2'b00 : req;
    for (int k = 0; k < 2; k++) begin
      int nreq, rdy, r0, r1, hit;
      logic [1:0] pv;
      nreq = int'(sreq[0]) + int'(sreq[1]);
      rdy  = (m_mode[k] == 0 && (depth[k] - m_cnt[k]) >= nreq) ? 1 : 0;
      pv   = (rdy != 0) ? sreq : 2'b00;
      r0 = 0; r1 = 0; hit = 0;
      if (m_mode[k] == 0) begin
        r0  = (m_cnt[k] >= 1 && vld[0]) ? 1 : 0;
        r1  = (r0 != 0 && !exc[0] && m_cnt[k] >= 2 && vld[1]) ? 1 : 0;
        hit = ((r0 != 0 && exc[0]) || (r1 != 0 && exc[1])) ? 1 : 0;
      end else if (m_mode[k] == 1) begin
        r0 = (m_cnt[k] >= 1) ? 1 : 0;
        r1 = (m_cnt[k] >= 2) ? 1 : 0;
      end
      check_val($sformatf("d_ready[%0d]", k), o_ready[k], 32'(rdy));
      check_val($sformatf("p_valid[%0d]", k), o_pv[k], 32'(pv));
      check_val($sformatf("d_rid[%0d]", k), o_rid[k],
                32'((((m_tail[k] + 1) % depth[k]) << 16) | m_tail[k]));
      check_val($sformatf("c_rrrid[%0d]", k), o_rr[k],
                32'((((m_head[k] + 1) % depth[k]) << 16) | m_head[k]));
      check_val($sformatf("c_retire[%0d]", k), o_ret[k], 32'((r1 << 1) | r0));
      check_val($sformatf("c_walk[%0d]", k), o_walk[k], 32'(m_mode[k] == 1));
      check_val($sformatf("flush[%0d]", k), o_flush[k], 32'(m_mode[k] != 0));
      check_val($sformatf("count[%0d]", k), o_cnt[k], 32'(m_cnt[k]));
      check_val($sformatf("empty[%0d]", k), o_empty[k], 32'(m_cnt[k] == 0));
      check_val($sformatf("full[%0d]", k), o_full[k], 32'(m_cnt[k] == depth[k]));
      na[k] = int'(pv[0]) + int'(pv[1]);
      nr[k] = r0 + r1;
      ht[k] = hit;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_tail[k] = (m_tail[k] + na[k]) % depth[k];
      m_head[k] = (m_head[k] + nr[k]) % depth[k];
      m_cnt[k]  = m_cnt[k] + na[k] - nr[k];
      case (m_mode[k])
        0:       if (ht[k] != 0) m_mode[k] = (m_cnt[k] == 0) ? 2 : 1;
        1:       m_mode[k] = (m_cnt[k] == 0) ? 2 : 1;
        default: m_mode[k] = 0;
      endcase
    end
  endtask

  initial begin
    logic [1:0] rq, vl, ex;
    do_reset();
    cycle(2'b00, 2'b00, 2'b00);

    // Back-to-back pair dispatch with nothing completing.
    repeat (3) cycle(2'b11, 2'b00, 2'b00);
    #1;
    check_val("fill_count6", o_cnt[0], 32'd6);
    check_val("fill_full2", o_full[1], 32'd1);

    // Small ROB: 3 occupied rejects a pair, accepts a single and becomes full.
    cycle(2'b00, 2'b01, 2'b00);
    cycle(2'b11, 2'b00, 2'b00);
    #1;
    check_val("pair_reject_count2", o_cnt[1], 32'd3);
    cycle(2'b01, 2'b00, 2'b00);
    #1;
    check_val("single_fill_full2", o_full[1], 32'd1);
    cycle(2'b10, 2'b00, 2'b00);

    // Exception at head with five occupied: one normal retire, two walk pairs, recovery.
    do_reset();
    cycle(2'b11, 2'b00, 2'b00);
    cycle(2'b11, 2'b00, 2'b00);
    cycle(2'b01, 2'b00, 2'b00);
    cycle(2'b00, 2'b11, 2'b01);
    #1;
    check_val("excp_walk6", o_walk[0], 32'd1);
    check_val("excp_count6", o_cnt[0], 32'd4);
    repeat (4) cycle(2'b11, 2'b11, 2'b00);
    #1;
    check_val("post_recover_count6", o_cnt[0], 32'd2);

    // Concurrent allocate and double retire keeps occupancy steady.
    do_reset();
    cycle(2'b11, 2'b00, 2'b00);
    cycle(2'b11, 2'b00, 2'b00);
    cycle(2'b11, 2'b11, 2'b00);
    #1;
    check_val("steady_count6", o_cnt[0], 32'd4);

    // Asynchronous reset in the middle of a walk.
    do_reset();
    cycle(2'b11, 2'b00, 2'b00);
    cycle(2'b11, 2'b00, 2'b00);
    cycle(2'b00, 2'b01, 2'b01);
    #1;
    check_val("pre_rst_flush6", o_flush[0], 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_flush6", o_flush[0], 32'd0);
    check_val("async_rst_count6", o_cnt[0], 32'd0);
    check_val("async_rst_flush2", o_flush[1], 32'd0);
    do_reset();

    // Randomized traffic including wraps, illegal requests and sporadic exceptions.
    for (int i = 0; i < 3000; i++) begin
      rq = 2'($urandom_range(0, 3));
      vl = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      ex = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      cycle(rq, vl, ex);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
